g_alu32_core: RTL and testbench



---
 rtl/g_alu32_pkg.sv | 15 +
 rtl/g_alu32_full_adder.sv | 13 +
 rtl/g_alu32_core.sv | 119 +++++++++++
 tb/tb_g_alu32_core.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/g_alu32_pkg.sv
// Shared opcode encodings and width default for the g_alu32 integer execute unit.
package g_alu32_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_XOR   = 3'd2;
    localparam logic [2:0] OP_NOT   = 3'd3;
    localparam logic [2:0] OP_ADD   = 3'd4;
    localparam logic [2:0] OP_SHL   = 3'd5;
    localparam logic [2:0] OP_SHR   = 3'd6;
    localparam logic [2:0] OP_TRUNC = 3'd7;

endpackage

// File: rtl/g_alu32_full_adder.sv
// One-bit full-adder cell; the core chains WIDTH of these into a ripple adder.
module g_alu32_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/g_alu32_core.sv
// 8-function ALU with registered result/carry: ripple adder, mux-stage shifters, truncate mask.
// Optional registered Zero flag when ALU_ZERO_FLAG_EN is defined.
module g_alu32_core
    import g_alu32_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             CI,
    input  logic [2:0]       A,
    output logic [WIDTH-1:0] FinalOut,
`ifdef ALU_ZERO_FLAG_EN
    output logic             Zero,
`endif
    output logic             CO
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] add_sum;
    logic             add_co;
    logic [WIDTH-1:0] shl_v;
    logic [WIDTH-1:0] shr_v;
    logic [WIDTH-1:0] keep_v;
    logic [WIDTH-1:0] result_d;
    logic             co_d;
    logic [WIDTH-1:0] result_q;
    logic             co_q;

    assign shamt = In2[SHW-1:0];

    // Each cell owns its carry net so the chain is a plain sequence of distinct wires.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic c_in;
        logic c_out;
        if (i == 0) begin : g_first
            assign c_in = CI;
        end else begin : g_next
            assign c_in = g_fa[i-1].c_out;
        end
        g_alu32_full_adder u_fa (
            .a    (In1[i]),
            .b    (In2[i]),
            .cin  (c_in),
            .sum  (add_sum[i]),
            .cout (c_out)
        );
    end
    assign add_co = g_fa[WIDTH-1].c_out;

    // Log2 barrel: stage s is a 2:1 mux between passing through and shifting by 2**s.
    // The truncate mask reuses the left-shift structure on all-ones and is inverted.
    always_comb begin
        shl_v  = In1;
        shr_v  = In1;
        keep_v = '1;
        for (int s = 0; s < SHW; s++) begin
            if (shamt[s]) begin
                shl_v  = shl_v  << (1 << s);
                shr_v  = shr_v  >> (1 << s);
                keep_v = keep_v << (1 << s);
            end
        end
    end

    always_comb begin
        result_d = '0;
        co_d     = 1'b0;
        case (A)
            OP_AND:   result_d = In1 & In2;
            OP_OR:    result_d = In1 | In2;
            OP_XOR:   result_d = In1 ^ In2;
            OP_NOT:   result_d = ~In1;
            OP_ADD: begin
                result_d = add_sum;
                co_d     = add_co;
            end
            OP_SHL:   result_d = shl_v;
            OP_SHR:   result_d = shr_v;
            OP_TRUNC: result_d = In1 & ~keep_v;
            default: begin
                result_d = '0;
                co_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            co_q     <= 1'b0;
        end else begin
            result_q <= result_d;
            co_q     <= co_d;
        end
    end

    assign FinalOut = result_q;
    assign CO       = co_q;

`ifdef ALU_ZERO_FLAG_EN
    logic zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b1;
        end else begin
            zero_q <= (result_d == '0);
        end
    end

    assign Zero = zero_q;
`endif

endmodule

// File: tb/tb_g_alu32_core.sv
// Bench for g_alu32_core: directed literal vectors plus a cycle-by-cycle arithmetic model.
module tb_g_alu32_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] In1;
    logic [31:0] In2;
    logic        CI;
    logic [2:0]  A;
    logic [31:0] FinalOut;
    logic        CO;
`ifdef ALU_ZERO_FLAG_EN
    logic        Zero;
`endif

    int n_cmp;
    int n_fail;

    logic [31:0] exp_out;
    logic        exp_co;
    logic        exp_vld;

    g_alu32_core #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .In1      (In1),
        .In2      (In2),
        .CI       (CI),
        .A        (A),
        .FinalOut (FinalOut),
`ifdef ALU_ZERO_FLAG_EN
        .Zero     (Zero),
`endif
        .CO       (CO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: what each opcode means, written with plain arithmetic.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
        int unsigned n;
        logic [63:0] keep;
        n = b % 32;
        case (op)
            3'd0: return {1'b0, a & b};
            3'd1: return {1'b0, a | b};
            3'd2: return {1'b0, a ^ b};
            3'd3: return {1'b0, ~a};
            3'd4: return {1'b0, a} + {1'b0, b} + {32'd0, c};
            3'd5: return {1'b0, a << n};
            3'd6: return {1'b0, a >> n};
            default: begin
                keep = (64'd1 << n) - 64'd1;
                return {1'b0, a & keep[31:0]};
            end
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_out <= 32'd0;
            exp_co  <= 1'b0;
            exp_vld <= 1'b1;
        end else begin
            {exp_co, exp_out} <= model(A, In1, In2, CI);
        end
    end

    always @(negedge clk) begin
        if (exp_vld === 1'b1) begin
            n_cmp++;
            if (FinalOut !== exp_out || CO !== exp_co) begin
                n_fail++;
                $display("FAIL model t=%0t: got out=%08h co=%b, want out=%08h co=%b",
                         $time, FinalOut, CO, exp_out, exp_co);
            end
`ifdef ALU_ZERO_FLAG_EN
            n_cmp++;
            if (Zero !== (rst_n ? (exp_out == 32'd0) : 1'b1)) begin
                n_fail++;
                $display("FAIL zero t=%0t: got %b for out=%08h", $time, Zero, exp_out);
            end
`endif
        end
    end

    task automatic check(input string nm, input logic [31:0] eo, input logic eco);
        n_cmp++;
        if (FinalOut !== eo || CO !== eco) begin
            n_fail++;
            $display("FAIL %s: got out=%08h co=%b, want out=%08h co=%b",
                     nm, FinalOut, CO, eo, eco);
        end
    endtask

    task automatic run_vec(input string nm, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic c,
                           input logic [31:0] eo, input logic eco);
        @(negedge clk);
        A = op; In1 = a; In2 = b; CI = c;
        @(posedge clk);
        #1;
        check(nm, eo, eco);
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        exp_vld = 1'b0;
        rst_n   = 1'b1;
        A = 3'd0; In1 = 32'd0; In2 = 32'd0; CI = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("reset_state", 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_vec("and",   3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hF000F000, 1'b0);
        run_vec("or",    3'd1, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hFFF0FFF0, 1'b0);
        run_vec("xor",   3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'h0FF00FF0, 1'b0);
        run_vec("not",   3'd3, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'h0F0F0F0F, 1'b0);
        run_vec("add_wrap", 3'd4, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1);
        run_vec("add_plain", 3'd4, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0);
        run_vec("shl4",  3'd5, 32'h80000001, 32'h00000004, 1'b1, 32'h00000010, 1'b0);
        run_vec("shr4",  3'd6, 32'h80000001, 32'h00000004, 1'b1, 32'h08000000, 1'b0);
        run_vec("shl32", 3'd5, 32'h80000001, 32'h00000020, 1'b0, 32'h80000001, 1'b0);
        run_vec("shr32", 3'd6, 32'h80000001, 32'h00000020, 1'b0, 32'h80000001, 1'b0);
        run_vec("trunc16", 3'd7, 32'hDEADBEEF, 32'h00000010, 1'b0, 32'h0000BEEF, 1'b0);
        run_vec("trunc0",  3'd7, 32'hDEADBEEF, 32'h00000000, 1'b0, 32'h00000000, 1'b0);
        run_vec("trunc31", 3'd7, 32'hDEADBEEF, 32'h0000001F, 1'b0, 32'h5EADBEEF, 1'b0);
        run_vec("trunc_hi", 3'd7, 32'hDEADBEEF, 32'hFFFFFFE4, 1'b0, 32'h0000000F, 1'b0);

        // Mid-stream reset, cleared without a clock edge.
        run_vec("pre_reset_add", 3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'd0, 1'b0);
        A = 3'bxxx;
        @(posedge clk);
        #1 check("reset_hold_xop", 32'd0, 1'b0);
        @(negedge clk);
        A = 3'd4;
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("first_after_release", 32'hFFFFFFFF, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            A   = 3'((i / 2) % 8);
            In1 = $urandom;
            In2 = $urandom;
            CI  = 1'($urandom_range(0, 1));
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
